fetch_stage_sramlike: RTL
=========================

# fetch_stage_sramlike

Instruction-fetch stage (pre-IF + IF) of the five-stage pipeline that drives the ID stage through the `fs_to_ds_valid`/`fs_to_ds_bus` handshake. It fetches from an SRAM-like instruction port that uses split address and data handshakes (`addr_ok`/`data_ok`) and may take any number of cycles to respond. It applies redirects from `br_bus` and cancels wrong-path fetches that are already in flight. At most one fetch request is outstanding at any time.

## Interface
- `RESET_PC`, default 32'h1c000000: address of the first fetch after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ds_allowin`  in  1  ID stage can accept an instruction this cycle.
- `br_bus`  in  34  {br_stall[33], br_taken[32], br_target[31:0]}; `br_taken` is a one-cycle pulse from a valid ID instruction.
- `fs_to_ds_valid`  out  1  instruction on `fs_to_ds_bus` is valid.
- `fs_to_ds_bus`  out  64  {inst[63:32], pc[31:0]}.
- `inst_sram_req`  out  1  fetch request.
- `inst_sram_wr`  out  1  tied to 0.
- `inst_sram_size`  out  2  tied to 2'b10 (word).
- `inst_sram_addr`  out  32  fetch address.
- `inst_sram_wstrb`  out  4  tied to 0.
- `inst_sram_wdata`  out  32  tied to 0.
- `inst_sram_addr_ok`  in  1  request accepted; a transfer occurs when `req & addr_ok`.
- `inst_sram_data_ok`  in  1  read data valid, returned in request order.
- `inst_sram_rdata`  in  32  instruction word.

## Operation
- State registers:
  - `fs_valid`, `fs_pc`
  - `inst_buf_valid`, `inst_buf`
  - `br_buf_valid`, `br_buf_target`
  - `drop_pending` (1 bit)
- `nextpc` priority:
  - `br_taken` gives `br_target`;
  - otherwise `br_buf_valid` gives `br_buf_target`;
  - otherwise `fs_pc + 4` (modulo 2^32, no overflow flag).
- `fs_ready_go = fs_valid & ~drop_pending & (inst_buf_valid | inst_sram_data_ok)`.
- `fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin)`.
- `fs_to_ds_valid = fs_ready_go & ~br_taken`.
- `inst = inst_buf_valid ? inst_buf : inst_sram_rdata`.
- Request: `inst_sram_req = ~reset & fs_allowin & ~br_stall & ~drop_pending`, with `inst_sram_addr = nextpc`.
  - While `addr_ok` is low, the address may change the next cycle (for example on a redirect). The slave samples only on `req & addr_ok`.
- On `req & addr_ok`: `fs_valid <= 1`, `fs_pc <= nextpc`, `br_buf_valid <= 0`.
- On `fs_ready_go & ds_allowin` without a new accepted request: `fs_valid <= 0`.
- Inst buffer: set when `data_ok` arrives while `fs_valid & ~drop_pending & ~ds_allowin`. It holds the word until ID accepts it, then clears.
- Redirect (`br_taken`) when the request at `nextpc` is not accepted that cycle: `br_buf_valid <= 1`, `br_buf_target <= br_target`.
- Cancel on `br_taken`, which means the instruction in IF is wrong-path:
  - IF already holds the instruction (buffered, or `data_ok` this cycle): `fs_valid <= 0`, `inst_buf_valid <= 0`.
  - IF is still waiting for `data_ok`: `fs_valid <= 0`, `drop_pending <= 1`. The next `data_ok` is discarded and clears `drop_pending`.
  - If IF is empty, only the redirect applies.
- `br_stall` blocks new requests only. It does not affect an instruction already held in IF.

## Timing
- Reset values:
  - `fs_valid`, `inst_buf_valid`, `br_buf_valid`, `drop_pending`: 0.
  - `fs_pc`: `RESET_PC - 4`.
  - All outputs: 0, except `inst_sram_size` = 2'b10.
- The first `req` is asserted in the first cycle after `reset` deasserts, with `addr = RESET_PC`.
- The SRAM port shares `reset`. Any transaction in flight at reset is abandoned on both sides, and no state survives.
- Latency:
  - `req & addr_ok` in cycle N.
  - `data_ok` no earlier than N+1.
  - `fs_to_ds_valid` in the same cycle as `data_ok` (combinational path).
- Throughput: one instruction per cycle when `addr_ok`/`data_ok` are single-cycle and `ds_allowin = 1`. The next request is issued in the same cycle as `data_ok`.
- Simultaneous events:
  - `data_ok` and `br_taken` in the same cycle: the word is dropped and `drop_pending` stays 0.
  - `data_ok` while `drop_pending`: discarded and not buffered. A new request may issue the following cycle.
  - `br_taken` with `br_stall`: the target is buffered and used once `br_stall` falls.

## Test plan
- Reset fetch:
  - Stimulus: release reset; `addr_ok = data_ok = 1` on every request (data one cycle later); `ds_allowin = 1`.
  - Required: addresses 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles. Each `fs_to_ds_bus` pc matches its returned inst.
- ID backpressure:
  - Stimulus: `ds_allowin = 0` for 3 cycles when `data_ok` returns inst 0xdeadbeef at pc 0x1c000004.
  - Required: word buffered, no new `req`, `fs_to_ds_valid` held at 1 with the same bus. The next request issues in the cycle `ds_allowin` rises.
- Redirect while waiting:
  - Stimulus: request for 0x1c000008 accepted; `data_ok` delayed 4 cycles; `br_taken` to 0x1c000100 in the cycle after acceptance.
  - Required: the delayed word is dropped. The next accepted address is 0x1c000100, and no instruction from 0x1c000008 reaches ID.
- Redirect while addr stalled:
  - Stimulus: `addr_ok = 0` for 3 cycles; `br_taken` to 0x1c000200 in the first of those cycles.
  - Required: `inst_sram_addr` becomes 0x1c000200, held until `addr_ok`, and `br_buf_valid` clears on acceptance.
- `br_stall` with pending target:
  - Stimulus: `br_stall = 1` for 2 cycles with a `br_taken` pulse to 0x1c000300.
  - Required: no `req` during the stall; the first request after the stall is 0x1c000300.
- Reset mid-flight:
  - Stimulus: assert `reset` with a request outstanding.
  - Required: the next cycle shows all state at reset values; the first request after release is 0x1c000000.

Source files
------------

// File: rtl/fetch_stage_sramlike.sv
// -----------------------------------------------------------------------------
// fetch_stage_sramlike
// Pre-IF + IF stage of the five-stage pipeline. Issues word fetches on an
// SRAM-like port with split address/data handshakes. Only one request is ever
// outstanding. Redirects come from ID through br_bus, and wrong-path fetches
// that are already in flight are cancelled.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   ds_allowin          ID can take an instruction this cycle
//   br_bus[33:0]        {br_stall, br_taken, br_target}
//   fs_to_ds_valid      fs_to_ds_bus carries a valid instruction
//   fs_to_ds_bus[63:0]  {inst, pc}
//   inst_sram_*         SRAM-like fetch port (read-only, word size)
// -----------------------------------------------------------------------------
module fetch_stage_sramlike #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [33:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    logic        fs_valid_r;
    logic [31:0] fs_pc_r;
    logic        inst_buf_valid_r;
    logic [31:0] inst_buf_r;
    logic        br_buf_valid_r;
    logic [31:0] br_buf_target_r;
    logic        drop_pending_r;

    logic        br_stall_s;
    logic        br_taken_s;
    logic [31:0] br_target_s;
    logic [31:0] nextpc_s;
    logic        fs_ready_go_s;
    logic        fs_allowin_s;
    logic        req_s;
    logic        xfer_s;
    logic        fs_has_inst_s;
    logic [31:0] inst_s;

    assign br_stall_s  = br_bus[33];
    assign br_taken_s  = br_bus[32];
    assign br_target_s = br_bus[31:0];

    // Next fetch address: a live redirect beats a buffered one, which beats sequential flow.
    always_comb begin
        nextpc_s = fs_pc_r + 32'd4;
        if (br_taken_s) begin
            nextpc_s = br_target_s;
        end else if (br_buf_valid_r) begin
            nextpc_s = br_buf_target_r;
        end else begin
            nextpc_s = fs_pc_r + 32'd4;
        end
    end

    // Handshake terms; fs_has_inst_s means the word is in hand (buffered or arriving now).
    always_comb begin
        fs_has_inst_s = inst_buf_valid_r | inst_sram_data_ok;
        fs_ready_go_s = fs_valid_r & ~drop_pending_r & fs_has_inst_s;
        fs_allowin_s  = ~fs_valid_r | (fs_ready_go_s & ds_allowin);
        req_s         = ~reset & fs_allowin_s & ~br_stall_s & ~drop_pending_r;
        xfer_s        = req_s & inst_sram_addr_ok;
        inst_s        = inst_buf_valid_r ? inst_buf_r : inst_sram_rdata;
    end

    // Port drive; address and ID bus are forced to zero while reset is held.
    always_comb begin
        inst_sram_req   = req_s;
        inst_sram_wr    = 1'b0;
        inst_sram_size  = 2'b10;
        inst_sram_wstrb = 4'b0000;
        inst_sram_wdata = 32'h0000_0000;
        if (reset) begin
            inst_sram_addr = 32'h0000_0000;
            fs_to_ds_valid = 1'b0;
            fs_to_ds_bus   = 64'h0;
        end else begin
            inst_sram_addr = nextpc_s;
            // A redirect in the same cycle means this instruction is wrong-path.
            fs_to_ds_valid = fs_ready_go_s & ~br_taken_s;
            fs_to_ds_bus   = {inst_s, fs_pc_r};
        end
    end

    // Stage state: IF slot, held instruction word, pending redirect and drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_r       <= 1'b0;
            fs_pc_r          <= RESET_PC - 32'd4;
            inst_buf_valid_r <= 1'b0;
            inst_buf_r       <= 32'h0000_0000;
            br_buf_valid_r   <= 1'b0;
            br_buf_target_r  <= 32'h0000_0000;
            drop_pending_r   <= 1'b0;
        end else begin
            if (xfer_s) begin
                fs_valid_r <= 1'b1;
                fs_pc_r    <= nextpc_s;
            end else if (br_taken_s) begin
                fs_valid_r <= 1'b0;
            end else if (fs_ready_go_s && ds_allowin) begin
                fs_valid_r <= 1'b0;
            end else begin
                fs_valid_r <= fs_valid_r;
            end

            if (br_taken_s) begin
                inst_buf_valid_r <= 1'b0;
            end else if (inst_sram_data_ok && fs_valid_r && !drop_pending_r &&
                         !ds_allowin && !inst_buf_valid_r) begin
                inst_buf_valid_r <= 1'b1;
                inst_buf_r       <= inst_sram_rdata;
            end else if (inst_buf_valid_r && ds_allowin) begin
                inst_buf_valid_r <= 1'b0;
            end else begin
                inst_buf_valid_r <= inst_buf_valid_r;
            end

            // A redirect that is not accepted right away is parked until it is.
            if (xfer_s) begin
                br_buf_valid_r <= 1'b0;
            end else if (br_taken_s) begin
                br_buf_valid_r  <= 1'b1;
                br_buf_target_r <= br_target_s;
            end else begin
                br_buf_valid_r <= br_buf_valid_r;
            end

            // A wrong-path request still in flight: swallow its data when it returns.
            if (drop_pending_r && inst_sram_data_ok) begin
                drop_pending_r <= 1'b0;
            end else if (br_taken_s && fs_valid_r && !drop_pending_r && !fs_has_inst_s) begin
                drop_pending_r <= 1'b1;
            end else begin
                drop_pending_r <= drop_pending_r;
            end
        end
    end

endmodule
